// File: rtl/sr_stream_pkg.sv
// Shared constants, parser state encoding and frame helpers for the
// Schumann-resonance field byte-stream receiver.
package sr_stream_pkg;

  localparam logic [7:0] SR_SYNC_BYTE      = 8'hA5;
  localparam int         SR_BYTES_PER_HARM = 3;

  typedef enum logic [1:0] {
    SR_HUNT    = 2'd0,
    SR_PAYLOAD = 2'd1,
    SR_CHECK   = 2'd2
  } sr_parse_state_e;

  // Total bytes on the wire for one frame: sync + payload + checksum.
  function automatic int sr_frame_len(input int num_harmonics);
    return 1 + num_harmonics * SR_BYTES_PER_HARM + 1;
  endfunction

  // Top byte of a sample carries two data bits; bits 7:2 must replicate bit 1.
  function automatic logic sr_sign_ok(input logic [7:0] b2);
    return (b2[7:2] == {6{b2[1]}});
  endfunction

endpackage

// File: rtl/sr_frame_fifo.sv
// Synchronous frame FIFO with registered full/empty flags and occupancy.
// A pop on an empty FIFO is honoured only when a push lands in the same cycle.
module sr_frame_fifo #(
  parameter int DW    = 90,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [LW-1:0] level_nxt_s;
  logic          full_r;
  logic          empty_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign push_ok_s = push && !full_r;
  assign pop_ok_s  = pop && (!empty_r || push_ok_s);
  assign pop_data  = mem_r[rd_ptr_r];
  assign full      = full_r;
  assign empty     = empty_r;
  assign level     = level_r;

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    level_nxt_s = level_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Storage array; pointer reset alone makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_nxt_s;
      full_r  <= (level_nxt_s == LW'(DEPTH));
      empty_r <= (level_nxt_s == {LW{1'b0}});
    end
  end

endmodule

// File: rtl/sr_field_stream_rx.sv
// Receives framed, checksummed field samples from a byte link, buffers whole
// frames and presents one per 4 kHz strobe on sr_field_packed.
module sr_field_stream_rx
  import sr_stream_pkg::*;
#(
  parameter int WIDTH         = 18,
  parameter int NUM_HARMONICS = 5,
  parameter int FIFO_DEPTH    = 4,
  parameter int HOLD_ON_EMPTY = 1,
  parameter int CNT_W         = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clk_en,
  input  logic                             enable,
  input  logic [7:0]                       s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic [NUM_HARMONICS*WIDTH-1:0]   sr_field_packed,
  output logic                             frame_strobe,
  output logic                             underrun,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic [CNT_W-1:0]                 frame_count,
  output logic [CNT_W-1:0]                 err_count
);
  localparam int FW            = NUM_HARMONICS * WIDTH;
  localparam int PAYLOAD_BYTES = sr_frame_len(NUM_HARMONICS) - 2;
  localparam int IW            = $clog2(PAYLOAD_BYTES);

  sr_parse_state_e state_r;
  sr_parse_state_e state_nxt_s;
  logic [IW-1:0]   byte_idx_r;
  logic [1:0]      pos_r;
  logic [7:0]      b0_r;
  logic [7:0]      b1_r;
  logic [7:0]      xor_r;
  logic            fmt_err_r;
  logic [FW-1:0]   stage_r;
  logic            push_pend_r;
  logic            drop_pend_r;
  logic            byte_acc_s;
  logic            last_byte_s;
  logic            frame_good_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic            pop_s;
  logic [FW-1:0]   fifo_rd_data_s;
  logic [WIDTH-1:0] sample_s;

  assign byte_acc_s   = s_valid && s_ready;
  assign last_byte_s  = (byte_idx_r == IW'(PAYLOAD_BYTES - 1));
  assign frame_good_s = (s_data == xor_r) && !fmt_err_r;
  assign sample_s     = WIDTH'({s_data[1:0], b1_r, b0_r});
  // A frame pushed this very cycle may be popped straight through.
  assign pop_s        = clk_en && enable && (!fifo_empty_s || push_pend_r);

  // Parser next state and byte-ready decode.
  always_comb begin
    state_nxt_s = state_r;
    s_ready     = 1'b1;
    case (state_r)
      SR_HUNT: begin
        if (s_valid && (s_data == SR_SYNC_BYTE)) begin
          state_nxt_s = SR_PAYLOAD;
        end else begin
          state_nxt_s = SR_HUNT;
        end
      end
      SR_PAYLOAD: begin
        if (s_valid && last_byte_s) begin
          state_nxt_s = SR_CHECK;
        end else begin
          state_nxt_s = SR_PAYLOAD;
        end
      end
      SR_CHECK: begin
        s_ready = !fifo_full_s;
        if (s_valid && !fifo_full_s) begin
          state_nxt_s = SR_HUNT;
        end else begin
          state_nxt_s = SR_CHECK;
        end
      end
      default: begin
        state_nxt_s = SR_HUNT;
        s_ready     = 1'b1;
      end
    endcase
  end

  // Parser state, sample assembly, running checksum and frame verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= SR_HUNT;
      byte_idx_r  <= {IW{1'b0}};
      pos_r       <= 2'd0;
      b0_r        <= 8'h00;
      b1_r        <= 8'h00;
      xor_r       <= 8'h00;
      fmt_err_r   <= 1'b0;
      stage_r     <= {FW{1'b0}};
      push_pend_r <= 1'b0;
      drop_pend_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      push_pend_r <= 1'b0;
      drop_pend_r <= 1'b0;
      if (byte_acc_s) begin
        case (state_r)
          SR_HUNT: begin
            byte_idx_r <= {IW{1'b0}};
            pos_r      <= 2'd0;
            xor_r      <= 8'h00;
            fmt_err_r  <= 1'b0;
          end
          SR_PAYLOAD: begin
            byte_idx_r <= byte_idx_r + IW'(1);
            xor_r      <= xor_r ^ s_data;
            case (pos_r)
              2'd0: begin
                b0_r  <= s_data;
                pos_r <= 2'd1;
              end
              2'd1: begin
                b1_r  <= s_data;
                pos_r <= 2'd2;
              end
              default: begin
                // Shift down so harmonic 0 ends up in the lowest slice.
                stage_r <= {sample_s, stage_r[FW-1:WIDTH]};
                pos_r   <= 2'd0;
                if (!sr_sign_ok(s_data)) begin
                  fmt_err_r <= 1'b1;
                end
              end
            endcase
          end
          SR_CHECK: begin
            push_pend_r <= frame_good_s;
            drop_pend_r <= !frame_good_s;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Saturating good/bad frame counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= {CNT_W{1'b0}};
      err_count   <= {CNT_W{1'b0}};
    end else begin
      if (push_pend_r && !(&frame_count)) begin
        frame_count <= frame_count + CNT_W'(1);
      end
      if (drop_pend_r && !(&err_count)) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

  // Output frame register with strobe and underrun pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_field_packed <= {FW{1'b0}};
      frame_strobe    <= 1'b0;
      underrun        <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      underrun     <= 1'b0;
      if (clk_en) begin
        if (!enable) begin
          sr_field_packed <= {FW{1'b0}};
        end else if (pop_s) begin
          sr_field_packed <= fifo_empty_s ? stage_r : fifo_rd_data_s;
          frame_strobe    <= 1'b1;
        end else begin
          underrun <= 1'b1;
          if (HOLD_ON_EMPTY == 0) begin
            sr_field_packed <= {FW{1'b0}};
          end
        end
      end
    end
  end

  sr_frame_fifo #(
    .DW    (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_pend_r),
    .push_data (stage_r),
    .pop       (pop_s),
    .pop_data  (fifo_rd_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (fifo_level)
  );

endmodule
